booth_mul_param: RTL and testbench

Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 8-bit `booth_mul_DP`, generalised to any operand width `WIDTH`, with a per-operation signed/unsigned mode, a busy/done handshake and an asynchronous active-low reset. It keeps the existing serial load protocol: a start strobe, then the multiplicand, then the multiplier, all on one shared `data_in` bus. The full-width product is held at the output until the next operation completes.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_mul_param_step.sv | 35 +++
 rtl/booth_mul_param.sv | 101 ++++++++++
 tb/tb_booth_mul_param.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the parametrised radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    RUN,
    DONE
  } state_t;

  // Booth pair {q0, q-1}
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_mul_param_step.sv
// One combinational Booth iteration: add/sub on acc, then arithmetic
// right shift of {acc, q, q_m1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   a,
  output logic [WIDTH+1:0] acc_next,
  output logic [WIDTH:0]   q_next,
  output logic             q_m1_next
);

  logic [WIDTH+1:0] a_x;
  logic [WIDTH+1:0] sum;
  logic [1:0]       pair;

  assign a_x  = {a[WIDTH], a};
  assign pair = {q[0], q_m1};

  always_comb begin
    sum = acc;
    unique case (1'b1)
      (pair == PAIR_SUB): sum = acc - a_x;
      (pair == PAIR_ADD): sum = acc + a_x;
      default:            sum = acc;
    endcase
  end

  assign {acc_next, q_next, q_m1_next} = {sum[WIDTH+1], sum, q};

endmodule

// File: rtl/booth_mul_param.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands loaded serially
// on data_in, signed or unsigned per operation.
module booth_mul_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic             mode;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   q;
  logic [WIDTH+1:0] acc;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] acc_n;
  logic [WIDTH:0]   q_n;
  logic             q_m1_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .a         (a),
    .acc_next  (acc_n),
    .q_next    (q_n),
    .q_m1_next (q_m1_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode    <= 1'b0;
      a       <= '0;
      q       <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_A;
            busy  <= 1'b1;
          end
        end
        LOAD_A: begin
          // operands widened by one bit so signed Booth covers unsigned too
          a     <= {is_signed & data_in[WIDTH-1], data_in};
          mode  <= is_signed;
          state <= LOAD_B;
        end
        LOAD_B: begin
          q     <= {mode & data_in[WIDTH-1], data_in};
          acc   <= '0;
          q_m1  <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) begin
            product <= {acc_n[WIDTH-2:0], q_n};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= LOAD_A;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_param.sv
// Directed + random bench for booth_mul_param at WIDTH=8 and WIDTH=16.
module tb_booth_mul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sign8, busy8, done8;
  logic [7:0]  d8;
  logic [15:0] p8;
  logic        start16, sign16, busy16, done16;
  logic [15:0] d16;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;
  logic [31:0] q8[$];
  logic [31:0] q16[$];

  booth_mul_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sign8),
    .data_in(d8), .busy(busy8), .done(done8), .product(p8)
  );

  booth_mul_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sign16),
    .data_in(d16), .busy(busy16), .done(done16), .product(p16)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("sb8_extra", {31'b0, done8}, 32'd0);
      else chk("p8", {16'b0, p8}, q8.pop_front());
    end
    if (done16) begin
      if (q16.size() == 0) chk("sb16_extra", {31'b0, done16}, 32'd0);
      else chk("p16", p16, q16.pop_front());
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [31:0] exp,
                      input bit timing);
    int n, nb;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; d8 = a; sign8 = s; n = 0; nb = int'(busy8);
    @(negedge clk);
    d8 = b; n = 1; nb += int'(busy8);
    q8.push_back(exp);
    @(negedge clk);
    d8 = 8'($urandom); n = 2; nb += int'(busy8);
    while (!done8 && n < 60) begin
      @(negedge clk);
      d8 = 8'($urandom); n++; nb += int'(busy8);
    end
    chk("done8", {31'b0, done8}, 32'd1);
    if (timing) begin
      chk("lat8", 32'(n), 32'd11);
      chk("busy8_cycles", 32'(nb), 32'd11);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp,
                       input bit timing);
    int n;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; d16 = a; sign16 = s; n = 0;
    @(negedge clk);
    d16 = b; n = 1;
    q16.push_back(exp);
    @(negedge clk);
    d16 = 16'($urandom); n = 2;
    while (!done16 && n < 80) begin
      @(negedge clk);
      d16 = 16'($urandom); n++;
    end
    chk("done16", {31'b0, done16}, 32'd1);
    if (timing) chk("lat16", 32'(n), 32'd19);
  endtask

  initial begin
    int dn, idx;
    int dcyc[$];
    logic [15:0] ra, rb;
    logic        rs;
    rst_n = 1'b0;
    start8 = 0; sign8 = 0; d8 = '0;
    start16 = 0; sign16 = 0; d16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_done", {31'b0, done8}, 32'd0);
    chk("rst_prod", {16'b0, p8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'd10, 8'd5, 1'b0, 32'h0032, 1'b1);
    @(negedge clk);
    chk("hold8", {16'b0, p8}, 32'h0032);
    chk("done_pulse", {31'b0, done8}, 32'd0);

    run8(8'h8A, 8'h05, 1'b1, 32'hFDB2, 1'b1);
    run8(8'h8A, 8'h05, 1'b0, 32'h02B2, 1'b1);
    run8(8'h80, 8'h80, 1'b1, 32'h4000, 1'b0);
    run8(8'h80, 8'h7F, 1'b1, 32'hC080, 1'b0);
    run8(8'hFF, 8'hFF, 1'b0, 32'hFE01, 1'b0);
    run8(8'h00, 8'hA7, 1'b1, 32'h0000, 1'b0);
    @(negedge clk);

    // start held high across three back-to-back operations
    start8 = 1'b1; idx = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done8) dcyc.push_back(idx);
      idx++; d8 = 8'd12 + 8'(k); sign8 = 1'b0;
      @(negedge clk);
      if (done8) dcyc.push_back(idx);
      idx++; d8 = 8'd9;
      q8.push_back(32'((12 + k) * 9));
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (done8) dcyc.push_back(idx);
        idx++; d8 = 8'($urandom); sign8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    chk("held_dones", 32'(dcyc.size()), 32'd3);
    if (dcyc.size() == 3) begin
      chk("held_gap1", 32'(dcyc[1] - dcyc[0]), 32'd12);
      chk("held_gap2", 32'(dcyc[2] - dcyc[1]), 32'd12);
    end
    repeat (2) @(negedge clk);

    // reset pulse in the middle of RUN
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; d8 = 8'h55; sign8 = 1'b0;
    @(negedge clk);
    d8 = 8'h33;
    repeat (5) @(negedge clk);
    chk("run_busy", {31'b0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    chk("abort_prod", {16'b0, p8}, 32'd0);
    chk("abort_done", {31'b0, done8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      dn += int'(done8);
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    run8(8'd3, 8'd7, 1'b0, 32'h0015, 1'b1);

    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (i == 0) ra = 16'hFFFF;
      if (i == 1) rb = 16'h7FFF;
      run16(ra, rb, rs, model16(ra, rb, rs), 1'b0);
    end
    repeat (3) @(negedge clk);

    chk("sb8_left", 32'(q8.size()), 32'd0);
    chk("sb16_left", 32'(q16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
